// File: rtl/fatori_fault_esc_mgr.sv
// fatori_fault_esc_mgr: multi-channel fault manager with minor-to-major escalation, fetch halt and reset-request FSM
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   alert_i             per-channel fault inputs, sampled every cycle
//   major_mask_i        per-channel class (1 = major, 0 = minor)
//   core_sleep_i        core idle in WFI, safe to reset
//   clear_i             clears minor count and minor_seen
//   fetch_enable_o      multi-bit fetch enable (On until the first major event)
//   core_reset_req_o    level reset request while in ASSERT_RST
//   fault_sticky_o, minor_seen_o, minor_cnt_o, major_cnt_o, cause_o,
//   first_idx_o, first_valid_o, sleep_timeout_o, esc_state_o   status
module fatori_fault_esc_mgr #(
  parameter int unsigned NUM_ALERTS       = 8,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned MINOR_ESC_THRESH = 4,
  parameter bit          RESET_ON_MAJOR   = 1'b1,
  parameter int unsigned SLEEP_TIMEOUT    = 1024,
  localparam int unsigned IDX_W = (NUM_ALERTS > 1) ? $clog2(NUM_ALERTS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_ALERTS-1:0] alert_i,
  input  logic [NUM_ALERTS-1:0] major_mask_i,
  input  logic                  core_sleep_i,
  input  logic                  clear_i,
  output logic [3:0]            fetch_enable_o,
  output logic                  core_reset_req_o,
  output logic                  fault_sticky_o,
  output logic                  minor_seen_o,
  output logic [CNT_W-1:0]      minor_cnt_o,
  output logic [CNT_W-1:0]      major_cnt_o,
  output logic [NUM_ALERTS-1:0] cause_o,
  output logic [IDX_W-1:0]      first_idx_o,
  output logic                  first_valid_o,
  output logic                  sleep_timeout_o,
  output logic [1:0]            esc_state_o
);
  localparam logic [3:0] MUBI_ON  = 4'b0101;
  localparam logic [3:0] MUBI_OFF = 4'b1010;
  localparam int unsigned TMR_W = (SLEEP_TIMEOUT > 1) ? $clog2(SLEEP_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, HALTED = 2'd1, WAIT_SLEEP = 2'd2, ASSERT_RST = 2'd3} state_e;
  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [CNT_W-1:0]      minor_cnt_q, minor_cnt_d, major_cnt_q, major_cnt_d;
  logic                  minor_seen_q, minor_seen_d, fault_q, fault_d;
  logic [NUM_ALERTS-1:0] cause_q, cause_d;
  logic [IDX_W-1:0]      first_idx_q, first_idx_d;
  logic                  first_valid_q, first_valid_d, timeout_q, timeout_d;
  logic                  minor_evt, esc_evt, major_evt, minor_sat, major_sat, timeout_hit;
  // Escalation needs the counter to actually step onto the threshold, so a
  // saturated counter never escalates even if all-ones equals THRESH-1.
  always_comb begin
    minor_evt   = |(alert_i & ~major_mask_i);
    minor_sat   = &minor_cnt_q;
    major_sat   = &major_cnt_q;
    esc_evt     = minor_evt && (MINOR_ESC_THRESH != 0) && !minor_sat &&
                  (32'(minor_cnt_q) == MINOR_ESC_THRESH - 1);
    major_evt   = (|(alert_i & major_mask_i)) || esc_evt;
    timeout_hit = (SLEEP_TIMEOUT != 0) && (32'(timer_q) == SLEEP_TIMEOUT - 1);
  end
  // A coincident minor event wins over clear_i, leaving the count at 1.
  always_comb begin
    minor_cnt_d   = clear_i ? CNT_W'(minor_evt) : minor_cnt_q + CNT_W'(minor_evt && !minor_sat);
    major_cnt_d   = major_cnt_q + CNT_W'(major_evt && !major_sat);
    minor_seen_d  = minor_evt || (minor_seen_q && !clear_i);
    fault_d       = fault_q || major_evt;
    cause_d       = cause_q | alert_i;
    first_valid_d = first_valid_q || (|alert_i);
    first_idx_d   = first_idx_q;
    for (int i = int'(NUM_ALERTS) - 1; i >= 0; i--)
      if (alert_i[i] && !first_valid_q) first_idx_d = IDX_W'(i);
    timer_d       = (state_q == WAIT_SLEEP) ? timer_q + TMR_W'(1) : '0;
    timeout_d     = timeout_q || (state_q == WAIT_SLEEP && !core_sleep_i && timeout_hit);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      minor_cnt_q   <= '0;
      major_cnt_q   <= '0;
      minor_seen_q  <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      minor_cnt_q   <= minor_cnt_d;
      major_cnt_q   <= major_cnt_d;
      minor_seen_q  <= minor_seen_d;
      fault_q       <= fault_d;
      cause_q       <= cause_d;
      first_idx_q   <= first_idx_d;
      first_valid_q <= first_valid_d;
      timeout_q     <= timeout_d;
    end
  end
  // Unreachable encodings fall into ASSERT_RST so a corrupted state still resets.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = major_evt ? (RESET_ON_MAJOR ? WAIT_SLEEP : HALTED) : IDLE;
      HALTED:     state_d = HALTED;
      WAIT_SLEEP: state_d = (core_sleep_i || timeout_hit) ? ASSERT_RST : WAIT_SLEEP;
      ASSERT_RST: state_d = ASSERT_RST;
      default:    state_d = ASSERT_RST;
    endcase
  end
  // Fetch enable is decoded from a single sticky bit so only On/Off can appear.
  always_comb begin
    core_reset_req_o = (state_q == ASSERT_RST);
    fetch_enable_o   = fault_q ? MUBI_OFF : MUBI_ON;
    esc_state_o      = state_q;
  end
  assign fault_sticky_o  = fault_q;
  assign minor_seen_o    = minor_seen_q;
  assign minor_cnt_o     = minor_cnt_q;
  assign major_cnt_o     = major_cnt_q;
  assign cause_o         = cause_q;
  assign first_idx_o     = first_idx_q;
  assign first_valid_o   = first_valid_q;
  assign sleep_timeout_o = timeout_q;
endmodule

// File: tb/tb_fatori_fault_esc_mgr.sv
// tb_fatori_fault_esc_mgr: scoreboard bench for three parameterisations of fatori_fault_esc_mgr
module tb_fatori_fault_esc_mgr;
  localparam logic [3:0] ON = 4'b0101, OFF = 4'b1010;
  typedef struct packed {
    logic [3:0]  fe;
    logic        req, sticky, seen;
    logic [15:0] mn, mj;
    logic [7:0]  cause;
    logic [2:0]  fidx;
    logic        fv, to;
    logic [1:0]  st;
  } obs_t;
  typedef struct { int k; obs_t e; } sb_t;
  int thr [3] = '{4, 0, 4};
  int cw  [3] = '{16, 4, 16};
  int rom [3] = '{1, 1, 0};
  int tmo [3] = '{8, 8, 8};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] al [3], mk [3];
  logic       sl [3], clr [3];
  wire  [3:0]  fe [3];
  wire         req [3], sticky [3], seen [3], fv [3], to [3];
  wire  [15:0] mn [3], mj [3];
  wire  [3:0]  mn1, mj1;
  wire  [7:0]  cause [3];
  wire  [2:0]  fidx [3];
  wire  [1:0]  st [3];
  obs_t m [3];
  int   tmr [3];
  sb_t  q [$];
  int   n_chk = 0, n_fail = 0;
  assign mn[1] = {12'b0, mn1};
  assign mj[1] = {12'b0, mj1};
  always #5 clk = ~clk;
  fatori_fault_esc_mgr #(.NUM_ALERTS(8), .CNT_W(16), .MINOR_ESC_THRESH(4), .RESET_ON_MAJOR(1'b1), .SLEEP_TIMEOUT(8)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .alert_i(al[0]), .major_mask_i(mk[0]), .core_sleep_i(sl[0]), .clear_i(clr[0]),
    .fetch_enable_o(fe[0]), .core_reset_req_o(req[0]), .fault_sticky_o(sticky[0]), .minor_seen_o(seen[0]),
    .minor_cnt_o(mn[0]), .major_cnt_o(mj[0]), .cause_o(cause[0]), .first_idx_o(fidx[0]), .first_valid_o(fv[0]),
    .sleep_timeout_o(to[0]), .esc_state_o(st[0]));
  fatori_fault_esc_mgr #(.NUM_ALERTS(8), .CNT_W(4), .MINOR_ESC_THRESH(0), .RESET_ON_MAJOR(1'b1), .SLEEP_TIMEOUT(8)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .alert_i(al[1]), .major_mask_i(mk[1]), .core_sleep_i(sl[1]), .clear_i(clr[1]),
    .fetch_enable_o(fe[1]), .core_reset_req_o(req[1]), .fault_sticky_o(sticky[1]), .minor_seen_o(seen[1]),
    .minor_cnt_o(mn1), .major_cnt_o(mj1), .cause_o(cause[1]), .first_idx_o(fidx[1]), .first_valid_o(fv[1]),
    .sleep_timeout_o(to[1]), .esc_state_o(st[1]));
  fatori_fault_esc_mgr #(.NUM_ALERTS(8), .CNT_W(16), .MINOR_ESC_THRESH(4), .RESET_ON_MAJOR(1'b0), .SLEEP_TIMEOUT(8)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .alert_i(al[2]), .major_mask_i(mk[2]), .core_sleep_i(sl[2]), .clear_i(clr[2]),
    .fetch_enable_o(fe[2]), .core_reset_req_o(req[2]), .fault_sticky_o(sticky[2]), .minor_seen_o(seen[2]),
    .minor_cnt_o(mn[2]), .major_cnt_o(mj[2]), .cause_o(cause[2]), .first_idx_o(fidx[2]), .first_valid_o(fv[2]),
    .sleep_timeout_o(to[2]), .esc_state_o(st[2]));

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t get_obs(int k);
    obs_t o;
    o.fe = fe[k]; o.req = req[k]; o.sticky = sticky[k]; o.seen = seen[k];
    o.mn = mn[k]; o.mj = mj[k]; o.cause = cause[k]; o.fidx = fidx[k];
    o.fv = fv[k]; o.to = to[k]; o.st = st[k];
    return o;
  endfunction

  task automatic compare(int k, obs_t e);
    obs_t o = get_obs(k);
    check_eq($sformatf("u%0d.fetch_enable", k), 32'(o.fe), 32'(e.fe));
    check_eq($sformatf("u%0d.reset_req", k), 32'(o.req), 32'(e.req));
    check_eq($sformatf("u%0d.fault_sticky", k), 32'(o.sticky), 32'(e.sticky));
    check_eq($sformatf("u%0d.minor_seen", k), 32'(o.seen), 32'(e.seen));
    check_eq($sformatf("u%0d.minor_cnt", k), 32'(o.mn), 32'(e.mn));
    check_eq($sformatf("u%0d.major_cnt", k), 32'(o.mj), 32'(e.mj));
    check_eq($sformatf("u%0d.cause", k), 32'(o.cause), 32'(e.cause));
    check_eq($sformatf("u%0d.first_idx", k), 32'(o.fidx), 32'(e.fidx));
    check_eq($sformatf("u%0d.first_valid", k), 32'(o.fv), 32'(e.fv));
    check_eq($sformatf("u%0d.sleep_timeout", k), 32'(o.to), 32'(e.to));
    check_eq($sformatf("u%0d.esc_state", k), 32'(o.st), 32'(e.st));
  endtask

  task automatic drain();
    sb_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      compare(s.k, s.e);
    end
  endtask

  task automatic model_step(int k);
    logic minor, major, esc;
    int   cmax = (1 << cw[k]) - 1;
    sb_t  s;
    minor = |(al[k] & ~mk[k]);
    esc   = minor && thr[k] != 0 && int'(m[k].mn) + 1 == thr[k] && int'(m[k].mn) < cmax;
    major = (|(al[k] & mk[k])) || esc;
    if (clr[k]) m[k].mn = minor ? 16'd1 : 16'd0;
    else if (minor && int'(m[k].mn) < cmax) m[k].mn = m[k].mn + 16'd1;
    m[k].seen = minor || (m[k].seen && !clr[k]);
    if (major && int'(m[k].mj) < cmax) m[k].mj = m[k].mj + 16'd1;
    if ((|al[k]) && !m[k].fv) begin
      for (int i = 7; i >= 0; i--) if (al[k][i]) m[k].fidx = 3'(i);
      m[k].fv = 1'b1;
    end
    m[k].cause = m[k].cause | al[k];
    case (m[k].st)
      2'd0: if (major) begin m[k].st = (rom[k] != 0) ? 2'd2 : 2'd1; tmr[k] = 0; end
      2'd2: begin
        if (sl[k]) m[k].st = 2'd3;
        else if (tmo[k] != 0 && tmr[k] == tmo[k] - 1) begin m[k].st = 2'd3; m[k].to = 1'b1; end
        else tmr[k]++;
      end
      default: ;
    endcase
    m[k].sticky = m[k].sticky || major;
    m[k].fe     = m[k].sticky ? OFF : ON;
    m[k].req    = (m[k].st == 2'd3);
    s.k = k; s.e = m[k];
    q.push_back(s);
  endtask

  task automatic cyc();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle_in();
    for (int k = 0; k < 3; k++) begin al[k] = '0; sl[k] = 1'b0; clr[k] = 1'b0; end
  endtask

  task automatic do_reset();
    sb_t s;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m[k] = '0; m[k].fe = ON; tmr[k] = 0;
      s.k = k; s.e = m[k];
      q.push_back(s);
    end
    #1;
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) mk[k] = 8'h20;
    mk[1] = 8'h00;
    idle_in();
    do_reset();
    // three minor pulses on ch0, no escalation yet
    for (int p = 0; p < 3; p++) begin
      al[0] = 8'h01; cyc();
      al[0] = 8'h00; cyc();
    end
    check_eq("minor3.cnt", 32'(mn[0]), 32'd3);
    check_eq("minor3.fetch", 32'(fe[0]), 32'(ON));
    check_eq("minor3.cause", 32'(cause[0]), 32'h01);
    check_eq("minor3.first", 32'(fidx[0]), 32'd0);
    check_eq("minor3.state", 32'(st[0]), 32'd0);
    // fourth pulse reaches the threshold and escalates
    al[0] = 8'h01; cyc(); al[0] = 8'h00;
    check_eq("esc.minor_cnt", 32'(mn[0]), 32'd4);
    check_eq("esc.major_cnt", 32'(mj[0]), 32'd1);
    check_eq("esc.fetch", 32'(fe[0]), 32'(OFF));
    check_eq("esc.state", 32'(st[0]), 32'd2);
    // timeout path: reset request exactly 8 cycles after entering WAIT_SLEEP
    n = 0;
    while (!req[0] && n < 20) begin cyc(); n++; end
    check_eq("timeout.latency", 32'(n), 32'd8);
    check_eq("timeout.flag", 32'(to[0]), 32'd1);
    // simultaneous major ch5 + minor ch2 on the halt-only instance
    al[2] = 8'h24; cyc(); al[2] = 8'h00;
    check_eq("mix.first_idx", 32'(fidx[2]), 32'd2);
    check_eq("mix.cause", 32'(cause[2]), 32'h24);
    check_eq("mix.state", 32'(st[2]), 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    check_eq("halt.req", 32'(req[2]), 32'd0);
    // saturation with escalation disabled, then clear with coincident minor
    al[1] = 8'h02;
    for (int i = 0; i < 20; i++) cyc();
    check_eq("sat.minor_cnt", 32'(mn[1]), 32'd15);
    check_eq("sat.major_cnt", 32'(mj[1]), 32'd0);
    clr[1] = 1'b1; cyc();
    check_eq("clr_evt.minor_cnt", 32'(mn[1]), 32'd1);
    al[1] = 8'h00; cyc();
    check_eq("clr_only.minor_seen", 32'(seen[1]), 32'd0);
    idle_in();
    // reset in the middle of WAIT_SLEEP
    do_reset();
    al[0] = 8'h20; cyc(); al[0] = 8'h00;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("midrst.pre_state", 32'(st[0]), 32'd2);
    do_reset();
    check_eq("midrst.fetch", 32'(fe[0]), 32'(ON));
    // sleep arriving at timer=3 wins without a timeout flag
    al[0] = 8'h20; cyc(); al[0] = 8'h00;
    for (int i = 0; i < 3; i++) cyc();
    sl[0] = 1'b1; cyc(); sl[0] = 1'b0;
    check_eq("sleep.req", 32'(req[0]), 32'd1);
    check_eq("sleep.timeout_flag", 32'(to[0]), 32'd0);
    for (int i = 0; i < 2; i++) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fatori_fault_esc_mgr.md
Name: fatori_fault_esc_mgr

Overview:
Parametrised multi-channel fault manager for the Ibex core. It takes a vector of alert channels, each classed minor or major by a runtime mask, and keeps saturating counters and sticky cause flags. A programmable threshold of minor events escalates to a major event. A major event halts fetch and, optionally, drives a reset-request FSM; that FSM waits for core sleep and has a bounded timeout so it can never hang.

Parameters:
NUM_ALERTS, 8, number of alert input channels (1..32)
CNT_W, 16, width of the minor and major event counters
MINOR_ESC_THRESH, 4, number of minor-event cycles that triggers a major escalation; 0 disables escalation
RESET_ON_MAJOR, 1'b1, 1: a major event starts the reset-request sequence; 0: halt only
SLEEP_TIMEOUT, 1024, cycles to wait for core_sleep_i before forcing reset; 0 waits forever
IDX_W, $clog2(NUM_ALERTS) (minimum 1), derived width of the channel index

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
alert_i  input  NUM_ALERTS  per-channel fault pulses or levels; sampled every cycle
major_mask_i  input  NUM_ALERTS  per-channel class: 1 = major, 0 = minor; quasi-static
core_sleep_i  input  1  core is in WFI with no outstanding bus activity
clear_i  input  1  software pulse that clears the minor bookkeeping
fetch_enable_o  output  ibex_mubi_t  fetch enable to the core
core_reset_req_o  output  1  level system-reset request
fault_sticky_o  output  1  a major event has occurred since reset
minor_seen_o  output  1  a minor event has occurred since reset or the last clear
minor_cnt_o  output  CNT_W  saturating count of minor-event cycles
major_cnt_o  output  CNT_W  saturating count of major-event cycles
cause_o  output  NUM_ALERTS  sticky record of every channel that has asserted
first_idx_o  output  IDX_W  index of the first channel to assert
first_valid_o  output  1  first_idx_o holds a valid index
sleep_timeout_o  output  1  sticky flag: reset was forced by timeout, not by sleep
esc_state_o  output  2  current FSM state

Behaviour:
- Reset values: fetch_enable_o = IbexMuBiOn; every other output is 0; the FSM is in IDLE (0).
- Event decode:
  - minor_evt = |(alert_i & ~major_mask_i)
  - esc_evt = minor_evt && MINOR_ESC_THRESH != 0 && minor_cnt_q == MINOR_ESC_THRESH-1
  - major_evt = |(alert_i & major_mask_i) | esc_evt
- All outputs are registered; an event at cycle t is visible at t+1.
- Counters add at most +1 per cycle, however many channels fire, and saturate at all-ones with no wrap. Escalation fires exactly once, on the increment that reaches the threshold. It is suppressed when saturation sits below the threshold.
- clear_i zeroes minor_cnt_o and minor_seen_o, which re-arms escalation. If minor_evt is high in the same cycle, the event wins: minor_cnt becomes 1 and minor_seen becomes 1. clear_i does not affect any other state.
- cause_o accumulates alert_i (bitwise OR) and is cleared only by reset.
- first_idx_o captures the lowest set index of alert_i on the first cycle with any alert; first_valid_o then stays 1.
- fetch_enable_o switches to IbexMuBiOff the cycle after the first major_evt and stays off until reset. Any encoding other than On or Off must never appear on this output.
- FSM states: IDLE=0, HALTED=1, WAIT_SLEEP=2, ASSERT_RST=3.
  - IDLE, on major_evt: go to WAIT_SLEEP if RESET_ON_MAJOR, otherwise go to HALTED.
  - HALTED: terminal.
  - WAIT_SLEEP: the timer starts at 0 on entry. core_sleep_i=1 moves to ASSERT_RST. If SLEEP_TIMEOUT != 0 and the timer equals SLEEP_TIMEOUT-1, move to ASSERT_RST and set sleep_timeout_o. If sleep and timeout occur in the same cycle, sleep wins and sleep_timeout_o stays 0.
  - ASSERT_RST: terminal; core_reset_req_o = 1 while in this state.
  - Illegal state encodings go to ASSERT_RST (fail-safe).
- Further major events after IDLE only increment the counter; they do not change the FSM.
- Assertion of rst_ni at any point, including mid-WAIT_SLEEP, immediately restores all reset values.

Test Plan:
- MINOR_ESC_THRESH=4, ch0 minor, minor pulses at cycles 1, 3, 5 -> minor_cnt=3, fetch stays On, cause_o=8'h01, first_idx=0, first_valid=1.
- Same setup with a 4th pulse -> minor_cnt=4, major_cnt=1, fault_sticky=1, fetch Off next cycle, esc_state goes 0 then 2.
- ch5 major with ch2 minor in the same cycle -> minor_cnt=1, major_cnt=1, first_idx=2, cause_o=8'h24.
- WAIT_SLEEP with SLEEP_TIMEOUT=8 and core_sleep_i held 0 -> core_reset_req_o=1 exactly 8 cycles after entry, sleep_timeout_o=1; repeat with core_sleep_i=1 at timer=3 -> req asserts, sleep_timeout_o=0.
- CNT_W=4 with 20 consecutive minor cycles and MINOR_ESC_THRESH=0 -> minor_cnt saturates at 15 and major_cnt=0; clear_i with a coincident minor -> minor_cnt=1.
- RESET_ON_MAJOR=0, major event -> FSM enters HALTED and core_reset_req_o stays 0; rst_ni low for 1 cycle mid-sequence -> all outputs return to reset values.
